ddr5_phy_crc_inserter_x4: RTL
=============================

DDR5_PHY_CRC_INSERTER_X4 -- requirements
Module: ddr5_phy_crc_inserter_x4

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all flops on rising edge.
REQ-002 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port wr_byte_en_i  input  1  byte strobe; the same strobe that drives the CRC generator enable.
REQ-004 SHALL have port wr_byte_i  input  8  write data byte, valid when wr_byte_en_i=1.
REQ-005 SHALL have port crc_code_i  input  8  CRC byte from the x4 CRC generator.
REQ-006 SHALL have port tx_ready_i  input  1  DQ slot permission from write timing.
REQ-007 SHALL have port dq_o  output  4  serialized DQ nibble.
REQ-008 SHALL have port dq_valid_o  output  1  dq_o carries a burst beat.
REQ-009 SHALL have port burst_last_o  output  1  final beat of the current burst.
REQ-010 SHALL have port fifo_full_o  output  1  both burst buffers occupied.
REQ-011 SHALL have port ovf_o  output  1  sticky flag: a burst was dropped.

Function
REQ-012 SHALL count enabled cycles 0..8 with a 4-bit collect counter; it advances only when wr_byte_en_i=1, holds otherwise, and wraps 8->0.
REQ-013 SHALL store wr_byte_i as byte[n] on enabled counts n=0..7 and crc_code_i on enabled count 8, the cycle in which the generator presents its CRC.
REQ-014 SHALL commit {byte[0..7], crc} into a 2-entry burst FIFO at the count-8 edge.
REQ-015 SHALL drop the burst, leave the FIFO unchanged and set ovf_o when count 8 occurs with the FIFO full; the collect counter still wraps to 0.
REQ-016 SHALL run a serializer FSM with states IDLE and SEND and a 5-bit beat counter.
REQ-017 SHALL move IDLE->SEND at an edge where the FIFO is non-empty and tx_ready_i=1; tx_ready_i is ignored during SEND.
REQ-018 SHALL drive beat k (k=0..15) with byte[k/2][3:0] when k is even and byte[k/2][7:4] when k is odd; beat 16 carries crc[3:0] and beat 17 carries crc[7:4].
REQ-019 SHALL register dq_o, dq_valid_o and burst_last_o; dq_valid_o is high for every beat of the burst with no gaps.
REQ-020 SHALL assert burst_last_o only on the final beat and pop the FIFO entry at that edge.
REQ-021 SHALL start the next burst in the cycle after the last beat, with no idle cycle, when an entry is pending and tx_ready_i=1 at the last-beat edge; otherwise it SHALL return to IDLE.
REQ-022 SHALL allow a commit and a pop at the same edge; occupancy is unchanged and no overflow occurs.
REQ-023 SHALL hold dq_o at 4'h0 while dq_valid_o=0.
REQ-024 SHALL set minimum latency at 1 cycle: with commit at edge E, serializer IDLE and tx_ready_i=1, beat 0 appears on the outputs after edge E+1.

Reset
REQ-025 SHALL, when rst_i=1, immediately clear the collect counter, beat counter, FIFO pointers, FSM (to IDLE), dq_o, dq_valid_o, burst_last_o, fifo_full_o and ovf_o to 0.
REQ-026 SHALL discard any partially collected or partially sent burst on reset and resume with a fresh count 0 after release.

Configuration
REQ-027 SHALL use macro DDR5_PHY_CRC_INSERT_EN; when it is defined, bursts are 18 beats with the CRC beats included.
REQ-028 SHALL, when DDR5_PHY_CRC_INSERT_EN is undefined, produce 16-beat bursts with burst_last_o on beat 15; crc_code_i is ignored, no CRC storage is built, and the collect counter still runs 0..8.

Structure
REQ-029 SHALL take from shared package ddr5_phy_pkg: DATA_BEATS=16, CRC_BEATS=2, BYTES_PER_BURST=8, FIFO_DEPTH=2, and the serializer state enum.
REQ-030 SHALL use one sub-module, ddr5_phy_burst_fifo (2-entry, 72-bit, full/empty flags); collect logic and serializer stay in the top module.

Verification
REQ-031 SHALL test single burst: bytes 0x10..0x17 then CRC 0xA5, tx_ready_i=1 -> 18 beats 0,1,1,1,2,1,...,7,1,5,A with burst_last_o on beat 17.
REQ-032 SHALL test stalled strobe: wr_byte_en_i low for 3 cycles between bytes 3 and 4 -> identical dq sequence, with first beat 1 cycle after the commit edge.
REQ-033 SHALL test back-to-back: two bursts committed while tx_ready_i=1 -> 36 contiguous dq_valid_o cycles with burst_last_o at beats 17 and 35.
REQ-034 SHALL test overflow: tx_ready_i=0 while 3 bursts commit -> fifo_full_o=1 after the 2nd and ovf_o=1 after the 3rd; raising tx_ready_i sends only bursts 1 and 2.
REQ-035 SHALL test reset mid-burst: rst_i pulsed at beat 7 -> all outputs 0 at once; a fresh burst after release sends correctly.
REQ-036 SHALL test macro off: the single-burst stimulus -> 16 beats, burst_last_o on beat 15, and no CRC nibbles.

Source files
------------

// File: rtl/ddr5_phy_pkg.sv
// Shared constants, serializer state and beat-select helper for the DDR5 PHY x4 CRC inserter.
// DDR5_PHY_CRC_INSERT_EN selects 18-beat bursts that carry the CRC nibbles after the data.
package ddr5_phy_pkg;

  localparam int DATA_BEATS      = 16;
  localparam int CRC_BEATS       = 2;
  localparam int BYTES_PER_BURST = 8;
  localparam int FIFO_DEPTH      = 2;

`ifdef DDR5_PHY_CRC_INSERT_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  localparam int BURST_BEATS = DATA_BEATS + (CRC_ON ? CRC_BEATS : 0);
  localparam int BURST_W     = BURST_BEATS * 4;
  localparam int LAST_BEAT   = BURST_BEATS - 1;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  // Beat k of a burst word is the k-th nibble counting from bit 0.
  function automatic logic [3:0] beat_nibble(input logic [BURST_W-1:0] word,
                                             input logic [4:0]         beat);
    logic [BURST_W-1:0] shifted;
    shifted = word >> {beat, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/ddr5_phy_burst_fifo.sv
// Two-entry burst buffer. Both the head and the entry behind it are visible so the
// serializer can chain a second burst straight after the first without an idle beat.
module ddr5_phy_burst_fifo
  import ddr5_phy_pkg::*;
#(
  parameter int WIDTH = 72
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full buffer is accepted only when the head leaves on the same edge.
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[~rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == 2'(FIFO_DEPTH));
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/ddr5_phy_crc_inserter_x4.sv
// DDR5 PHY x4 write-path CRC inserter: collects 8 bytes plus the generator CRC, buffers
// two bursts and serializes nibbles. Define DDR5_PHY_CRC_INSERT_EN for 18-beat bursts.
module ddr5_phy_crc_inserter_x4
  import ddr5_phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_byte_en_i,
  input  logic [7:0] wr_byte_i,
  input  logic [7:0] crc_code_i,
  input  logic       tx_ready_i,
  output logic [3:0] dq_o,
  output logic       dq_valid_o,
  output logic       burst_last_o,
  output logic       fifo_full_o,
  output logic       ovf_o
);

  logic [3:0]                   cnt_q, cnt_d;
  logic [7:0]                   bytes_q [BYTES_PER_BURST];
  logic [7:0]                   bytes_d [BYTES_PER_BURST];
  logic [BYTES_PER_BURST*8-1:0] data_vec;
  logic [BURST_W-1:0]           commit_word, fifo_head, fifo_next;
  logic [1:0]                   fifo_count;
  logic                         fifo_full, fifo_empty;
  logic                         commit, push, pop;
  ser_state_e                   state_q, state_d;
  logic [4:0]                   beat_q, beat_d;
  logic [3:0]                   dq_q, dq_d;
  logic                         dq_valid_q, dq_valid_d;
  logic                         last_q, last_d;
  logic                         ovf_q, ovf_d;

  generate
    for (genvar gi = 0; gi < BYTES_PER_BURST; gi++) begin : g_pack
      assign data_vec[gi*8 +: 8] = bytes_q[gi];
    end
  endgenerate

`ifdef DDR5_PHY_CRC_INSERT_EN
  // The CRC is valid only in the count-8 cycle, so it goes straight into the burst word.
  assign commit_word = {crc_code_i, data_vec};
`else
  logic unused_crc;
  assign unused_crc  = ^crc_code_i;
  assign commit_word = data_vec;
`endif

  always_comb begin
    commit  = wr_byte_en_i && (cnt_q == 4'd8);
    cnt_d   = cnt_q;
    bytes_d = bytes_q;
    if (wr_byte_en_i) begin
      cnt_d = commit ? 4'd0 : cnt_q + 4'd1;
      if (!commit) begin
        bytes_d[cnt_q[2:0]] = wr_byte_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    dq_d       = 4'h0;
    dq_valid_d = 1'b0;
    last_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty && tx_ready_i) begin
          state_d    = SER_SEND;
          beat_d     = 5'd0;
          dq_d       = beat_nibble(fifo_head, 5'd0);
          dq_valid_d = 1'b1;
        end
      end
      SER_SEND: begin
        if (beat_q == 5'(LAST_BEAT)) begin
          pop    = 1'b1;
          beat_d = 5'd0;
          // Chain only when a second entry is already buffered behind the departing one.
          if ((fifo_count == 2'd2) && tx_ready_i) begin
            dq_d       = beat_nibble(fifo_next, 5'd0);
            dq_valid_d = 1'b1;
          end else begin
            state_d = SER_IDLE;
          end
        end else begin
          beat_d     = beat_q + 5'd1;
          dq_d       = beat_nibble(fifo_head, beat_q + 5'd1);
          dq_valid_d = 1'b1;
          last_d     = ((beat_q + 5'd1) == 5'(LAST_BEAT));
        end
      end
      default: state_d = SER_IDLE;
    endcase
    push  = commit && (!fifo_full || pop);
    ovf_d = ovf_q || (commit && !push);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    bytes_q <= bytes_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SER_IDLE;
      beat_q     <= 5'd0;
      dq_q       <= 4'h0;
      dq_valid_q <= 1'b0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      dq_q       <= dq_d;
      dq_valid_q <= dq_valid_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
    end
  end

  ddr5_phy_burst_fifo #(
    .WIDTH(BURST_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (push),
    .pop_i    (pop),
    .wr_data_i(commit_word),
    .head_o   (fifo_head),
    .next_o   (fifo_next),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign dq_o         = dq_q;
  assign dq_valid_o   = dq_valid_q;
  assign burst_last_o = last_q;
  assign fifo_full_o  = fifo_full;
  assign ovf_o        = ovf_q;

endmodule
